// File: rtl/control_unit.sv
// control_unit: Moore sequencer for a small register/ALU/FPU datapath.
// Decodes III_XXX_YYY instructions into bus-source and load enables.
// Optional FPU sequencing (fadd, FWAIT timeout, FPErr) is built only when
// the macro CONTROL_UNIT_FPU_EN is defined; otherwise opcode 100 is a NOP.
module control_unit #(
  parameter int unsigned FP_TIMEOUT = 16
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] DIN,
  input  logic       FPDone,
  output logic [7:0] Rout,
  output logic       Gout,
  output logic       GFout,
  output logic       Dinout,
  output logic [7:0] Rin,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       FPStart,
  output logic       Done,
  output logic       Busy,
  output logic       FPErr
);

  // Reject an out-of-range timeout at elaboration.
  if (FP_TIMEOUT < 2 || FP_TIMEOUT > 255) begin : g_bad_timeout
    $error("control_unit: FP_TIMEOUT must be in 2..255");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_T1    = 3'd1;
  localparam logic [2:0] ST_T2    = 3'd2;
  localparam logic [2:0] ST_T3    = 3'd3;

  localparam logic [2:0] OP_MV    = 3'b000;
  localparam logic [2:0] OP_MVI   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;

`ifdef CONTROL_UNIT_FPU_EN
  localparam logic [2:0] ST_FWAIT    = 3'd4;
  localparam logic [2:0] OP_FADD     = 3'b100;
  localparam logic [7:0] TIMEOUT_LIM = 8'(FP_TIMEOUT);
  localparam logic [7:0] TIMEOUT_M1  = 8'(FP_TIMEOUT - 1);
`endif

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [8:0] r_ir;
  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [7:0] w_x_oh;
  logic [7:0] w_y_oh;
  logic       w_accept;

  assign w_op     = r_ir[8:6];
  assign w_x      = r_ir[5:3];
  assign w_y      = r_ir[2:0];
  assign w_x_oh   = 8'b1 << w_x;
  assign w_y_oh   = 8'b1 << w_y;
  assign w_accept = (r_state == ST_IDLE) && Run;

`ifdef CONTROL_UNIT_FPU_EN
  logic [7:0] r_cnt;
  logic       r_fp_err;
  assign FPErr = r_fp_err;
`else
  logic w_unused_fpdone;
  assign w_unused_fpdone = FPDone;
  assign FPErr = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Instruction register, loaded only when a Run is accepted in IDLE.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)       r_ir <= 9'd0;
    else if (w_accept) r_ir <= DIN;
  end

`ifdef CONTROL_UNIT_FPU_EN
  // FWAIT cycle counter and sticky timeout flag (cleared by the next accepted Run).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt    <= 8'd0;
      r_fp_err <= 1'b0;
    end else begin
      if (w_accept) r_fp_err <= 1'b0;
      if (r_state == ST_T2 && w_op == OP_FADD) r_cnt <= 8'd0;
      if (r_state == ST_FWAIT && !FPDone) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == TIMEOUT_M1) r_fp_err <= 1'b1;
      end
    end
  end
`endif

  // Next-state and Moore output decode from state, IR and counter.
  always_comb begin
    w_state_nxt = r_state;
    Rout        = 8'd0;
    Gout        = 1'b0;
    GFout       = 1'b0;
    Dinout      = 1'b0;
    Rin         = 8'd0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    AddSub      = 1'b0;
    FPStart     = 1'b0;
    Done        = 1'b0;
    Busy        = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (Run) w_state_nxt = ST_T1;
      end

      ST_T1: begin
        w_state_nxt = ST_IDLE;
        case (w_op)
          OP_MV: begin
            Rout = w_y_oh;
            Rin  = w_x_oh;
            Done = 1'b1;
          end
          OP_MVI: begin
            Dinout = 1'b1;
            Rin    = w_x_oh;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout        = w_x_oh;
            Ain         = 1'b1;
            w_state_nxt = ST_T2;
          end
`ifdef CONTROL_UNIT_FPU_EN
          OP_FADD: begin
            Rout        = w_x_oh;
            Ain         = 1'b1;
            w_state_nxt = ST_T2;
          end
`endif
          default: Done = 1'b1;
        endcase
      end

      ST_T2: begin
        Rout = w_y_oh;
`ifdef CONTROL_UNIT_FPU_EN
        if (w_op == OP_FADD) begin
          FPStart     = 1'b1;
          w_state_nxt = ST_FWAIT;
        end else begin
          Gin         = 1'b1;
          AddSub      = w_op[0];
          w_state_nxt = ST_T3;
        end
`else
        Gin         = 1'b1;
        AddSub      = w_op[0];
        w_state_nxt = ST_T3;
`endif
      end

      ST_T3: begin
        Done        = 1'b1;
        w_state_nxt = ST_IDLE;
`ifdef CONTROL_UNIT_FPU_EN
        if (w_op == OP_FADD) begin
          // Counter at the limit means FWAIT timed out: finish without writeback.
          if (r_cnt != TIMEOUT_LIM) begin
            GFout = 1'b1;
            Rin   = w_x_oh;
          end
        end else begin
          Gout = 1'b1;
          Rin  = w_x_oh;
        end
`else
        Gout = 1'b1;
        Rin  = w_x_oh;
`endif
      end

`ifdef CONTROL_UNIT_FPU_EN
      ST_FWAIT: begin
        // FPDone has priority over a timeout in the same cycle.
        if (FPDone || r_cnt == TIMEOUT_M1) w_state_nxt = ST_T3;
      end
`endif

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit.
// Adapts its reference model to the CONTROL_UNIT_FPU_EN build option.
module tb_control_unit;

`ifdef CONTROL_UNIT_FPU_EN
  localparam bit FPU = 1'b1;
`else
  localparam bit FPU = 1'b0;
`endif
  localparam int TMO = 16;

  typedef logic [25:0] vec_t;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] DIN;
  logic       FPDone;
  logic [7:0] Rout;
  logic       Gout, GFout, Dinout;
  logic [7:0] Rin;
  logic       Ain, Gin, AddSub, FPStart, Done, Busy, FPErr;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t mon_a;
  vec_t mon_e;
  int   mon_src;

  control_unit #(.FP_TIMEOUT(TMO)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .FPDone(FPDone),
    .Rout(Rout), .Gout(Gout), .GFout(GFout), .Dinout(Dinout), .Rin(Rin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .FPStart(FPStart),
    .Done(Done), .Busy(Busy), .FPErr(FPErr)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Current DUT outputs as one vector.
  function automatic vec_t pack_out();
    return {Rout, Gout, GFout, Dinout, Rin, Ain, Gin, AddSub, FPStart, Done, Busy, FPErr};
  endfunction

  // Expected busy-cycle vector: src={G,GF,Din}, ctl={Ain,Gin,AddSub,FPStart}.
  function automatic vec_t mk(input logic [7:0] rout, input logic [2:0] src,
                              input logic [7:0] rin, input logic [3:0] ctl,
                              input logic done, input logic err);
    return {rout, src, rin, ctl, done, 1'b1, err};
  endfunction

  task automatic cmp(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected output sequence of one instruction, pushed to the scoreboard.
  // Returns 1 when the instruction ends in an FPU timeout.
  function automatic bit model(input logic [8:0] ins, input int fpd);
    logic [2:0] op;
    logic [7:0] xo;
    logic [7:0] yo;
    int         n;
    bit         ok;
    op = ins[8:6];
    xo = 8'b1 << ins[5:3];
    yo = 8'b1 << ins[2:0];
    case (op)
      3'b000: exp_q.push_back(mk(yo, 3'b000, xo, 4'b0000, 1'b1, 1'b0));
      3'b001: exp_q.push_back(mk(8'd0, 3'b001, xo, 4'b0000, 1'b1, 1'b0));
      3'b010, 3'b011: begin
        exp_q.push_back(mk(xo, 3'b000, 8'd0, 4'b1000, 1'b0, 1'b0));
        exp_q.push_back(mk(yo, 3'b000, 8'd0, {2'b01, op[0], 1'b0}, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd0, 3'b100, xo, 4'b0000, 1'b1, 1'b0));
      end
      3'b100: begin
        if (FPU) begin
          ok = (fpd >= 1 && fpd <= TMO);
          n  = ok ? fpd : TMO;
          exp_q.push_back(mk(xo, 3'b000, 8'd0, 4'b1000, 1'b0, 1'b0));
          exp_q.push_back(mk(yo, 3'b000, 8'd0, 4'b0001, 1'b0, 1'b0));
          for (int k = 0; k < n; k++)
            exp_q.push_back(mk(8'd0, 3'b000, 8'd0, 4'b0000, 1'b0, 1'b0));
          if (ok) exp_q.push_back(mk(8'd0, 3'b010, xo, 4'b0000, 1'b1, 1'b0));
          else    exp_q.push_back(mk(8'd0, 3'b000, 8'd0, 4'b0000, 1'b1, 1'b1));
          return !ok;
        end else begin
          exp_q.push_back(mk(8'd0, 3'b000, 8'd0, 4'b0000, 1'b1, 1'b0));
        end
      end
      default: exp_q.push_back(mk(8'd0, 3'b000, 8'd0, 4'b0000, 1'b1, 1'b0));
    endcase
    return 1'b0;
  endfunction

  // Issue one instruction; call at posedge+1 while the DUT is idle.
  // fpd = cycles after FPStart that FPDone pulses (0 = never).
  task automatic issue(input logic [8:0] ins, input int fpd, input bit release_rst);
    int  n0;
    int  n;
    bit  abort;
    n0    = exp_q.size();
    abort = model(ins, fpd);
    n     = exp_q.size() - n0;
    Run    = 1'b1;
    DIN    = ins;
    FPDone = 1'($urandom);
    if (release_rst) begin
      #2 Resetn = 1'b1;
    end
    @(posedge Clock); #1;
    for (int i = 0; i < n; i++) begin
      Run    = 1'($urandom);
      DIN    = (ins[8:6] == 3'b001 && i == 0) ? 9'h005 : 9'($urandom);
      FPDone = 1'($urandom);
      if (FPU && ins[8:6] == 3'b100 && i >= 2) FPDone = (i == 1 + fpd);
      @(posedge Clock); #1;
    end
    Run    = 1'b0;
    FPDone = 1'($urandom);
    cmp("fperr_after_instr", 26'(FPErr), 26'(abort));
  endtask

  // Scoreboard monitor: one-hot bus sources every cycle, pops expected vector on Busy.
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      mon_a   = pack_out();
      mon_src = $countones({Rout, Gout, GFout, Dinout});
      cmp("bus_onehot", 26'(mon_src > 1), 26'd0);
      if (Busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_busy", mon_a, 26'd0);
        end else begin
          mon_e = exp_q.pop_front();
          cmp("busy_cycle", mon_a, mon_e);
        end
      end else begin
        cmp("idle_cycle", mon_a & ~26'h1, 26'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] ins;
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 9'h1ff;
    FPDone = 1'b1;
    #7;
    cmp("reset_outputs", pack_out(), 26'd0);
    @(posedge Clock); #1;
    cmp("reset_hold_run", pack_out(), 26'd0);

    // mvi R3 released straight out of reset, then directed patterns.
    issue(9'b001_011_000, 0, 1'b1);
    issue(9'b010_001_010, 0, 1'b0);
    issue(9'b011_001_010, 0, 1'b0);
    issue(9'b000_010_110, 0, 1'b0);
    issue(9'b000_101_101, 0, 1'b0);
    issue(9'b101_001_010, 0, 1'b0);
    issue(9'b110_111_000, 0, 1'b0);
    issue(9'b111_000_111, 0, 1'b0);
    issue(9'b100_000_111, 5, 1'b0);
    issue(9'b100_000_111, TMO, 1'b0);
    issue(9'b100_000_111, 0, 1'b0);
    repeat (3) begin
      @(posedge Clock); #1;
      cmp("fperr_sticky_idle", 26'(FPErr), 26'(FPU));
    end
    issue(9'b001_100_000, 0, 1'b0);
    issue(9'b100_110_011, TMO + 1, 1'b0);

    // Asynchronous reset in T2 of sub, then a normal run after release.
    void'(model(9'b011_010_011, 0));
    Run = 1'b1;
    DIN = 9'b011_010_011;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(posedge Clock); #1;
    #1 Resetn = 1'b0;
    #1;
    cmp("reset_mid_sub", pack_out(), 26'd0);
    exp_q.delete();
    @(posedge Clock); #1;
    cmp("reset_held", pack_out(), 26'd0);
    issue(9'b011_001_010, 0, 1'b1);

    // Random stream with back-to-back Run and occasional gaps.
    for (int t = 0; t < 250; t++) begin
      ins = 9'($urandom);
      issue(ins, int'($urandom_range(0, TMO + 4)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge Clock); #1;
        end
      end
    end

    repeat (3) @(posedge Clock);
    #1;
    cmp("scoreboard_drained", 26'(exp_q.size()), 26'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
